// File: rtl/fetch_seq_if.sv
// PC-register load port and instruction-memory handshake, seen from the
// fetch sequencer (master) and from the pc register / memory pair (slave).
interface fetch_seq_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;
    logic          pc_load_n;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_data;

    modport master (
        input  pc_q,
        input  imem_ack,
        input  imem_data,
        output pc_d,
        output pc_load_n,
        output imem_req,
        output imem_addr
    );

    modport slave (
        output pc_q,
        output imem_ack,
        output imem_data,
        input  pc_d,
        input  pc_load_n,
        input  imem_req,
        input  imem_addr
    );
endinterface

// File: rtl/fetch_seq.sv
// Fetch sequencer: loads the PC register, runs the req/ack instruction fetch,
// holds the fetched word for decode and handles stall, branch redirect and halt.
module fetch_seq #(
    parameter int            AW       = 16,
    parameter int            DW       = 16,
    parameter int            INC      = 2,
    parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
    input  logic           clk,
    input  logic           clr,
    fetch_seq_if.master    bus,
    input  logic           stall,
    input  logic           br_valid,
    input  logic [AW-1:0]  br_target,
    input  logic           halt,
    output logic [DW-1:0]  ir,
    output logic [AW-1:0]  ir_pc,
    output logic           ir_valid,
    output logic           halted
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t        state_q;
    logic          squash_q;
    logic          halt_pend_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] ir_q;
    logic [AW-1:0] ir_pc_q;
    logic          ir_valid_q;

    logic [AW-1:0] pc_d_s;
    logic          pc_load_n_s;
    logic          imem_req_s;
    logic          halted_s;

    // PC load strobe, fetch request and halted flag decoded from state and inputs
    always_comb begin
        pc_d_s      = bus.pc_q;
        pc_load_n_s = 1'b1;
        imem_req_s  = 1'b0;
        halted_s    = 1'b0;
        if (!clr) begin
            pc_d_s = {AW{1'b0}};
        end else begin
            case (state_q)
                S_BOOT: begin
                    pc_load_n_s = 1'b0;
                    pc_d_s      = RESET_PC;
                end
                S_REQ: begin
                    imem_req_s = 1'b1;
                    // a redirect always wins over the sequential increment
                    if (br_valid) begin
                        pc_load_n_s = 1'b0;
                        pc_d_s      = br_target;
                    end else if (bus.imem_ack && !squash_q) begin
                        pc_load_n_s = 1'b0;
                        pc_d_s      = addr_q + AW'(INC);
                    end else begin
                        pc_load_n_s = 1'b1;
                    end
                end
                S_VALID: begin
                    if (br_valid) begin
                        pc_load_n_s = 1'b0;
                        pc_d_s      = br_target;
                    end else begin
                        pc_load_n_s = 1'b1;
                    end
                end
                S_HALT: begin
                    halted_s = 1'b1;
                end
                default: begin
                    pc_load_n_s = 1'b1;
                end
            endcase
        end
    end

    // Sequencer state, fetch address, squash/halt flags and held instruction
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q     <= S_BOOT;
            squash_q    <= 1'b0;
            halt_pend_q <= 1'b0;
            addr_q      <= {AW{1'b0}};
            ir_q        <= {DW{1'b0}};
            ir_pc_q     <= {AW{1'b0}};
            ir_valid_q  <= 1'b0;
        end else begin
            if (halt && (state_q != S_HALT)) begin
                halt_pend_q <= 1'b1;
            end
            case (state_q)
                S_BOOT: begin
                    state_q <= S_REQ;
                    addr_q  <= RESET_PC;
                end
                S_REQ: begin
                    // the handshake always completes; squashed data is dropped
                    if (bus.imem_ack) begin
                        if (squash_q || br_valid) begin
                            squash_q <= 1'b0;
                            if (halt_pend_q) begin
                                state_q <= S_HALT;
                            end else begin
                                state_q <= S_REQ;
                                addr_q  <= br_valid ? br_target : bus.pc_q;
                            end
                        end else begin
                            ir_q       <= bus.imem_data;
                            ir_pc_q    <= addr_q;
                            ir_valid_q <= 1'b1;
                            state_q    <= S_VALID;
                        end
                    end else if (br_valid) begin
                        squash_q <= 1'b1;
                    end
                end
                S_VALID: begin
                    if (br_valid) begin
                        ir_valid_q <= 1'b0;
                        addr_q     <= br_target;
                        state_q    <= halt_pend_q ? S_HALT : S_REQ;
                    end else if (!stall) begin
                        ir_valid_q <= 1'b0;
                        addr_q     <= bus.pc_q;
                        state_q    <= halt_pend_q ? S_HALT : S_REQ;
                    end
                end
                S_HALT: begin
                    ir_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= S_BOOT;
                end
            endcase
        end
    end

    assign bus.pc_d      = pc_d_s;
    assign bus.pc_load_n = pc_load_n_s;
    assign bus.imem_req  = imem_req_s;
    assign bus.imem_addr = addr_q;
    assign ir            = ir_q;
    assign ir_pc         = ir_pc_q;
    assign ir_valid      = ir_valid_q;
    assign halted        = halted_s;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed scenarios plus a randomized run checked
// against an instruction-stream model (expected next PC and memory contents).
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        stall, br_valid, halt, m_ack;
    logic [15:0] br_target;
    logic [15:0] ir, ir_pc, ir_b, ir_pc_b;
    logic        ir_valid, halted, ir_valid_b, halted_b;
    logic [15:0] pc_reg = 16'h0000;
    logic [15:0] pc_reg_b = 16'h0000;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: mem_word = 16'h1111;
            16'h0002: mem_word = 16'h2222;
            16'h0004: mem_word = 16'h3333;
            default:  mem_word = a ^ 16'h5A3C;
        endcase
    endfunction

    fetch_seq_if #(.AW(16), .DW(16)) mif ();
    fetch_seq_if #(.AW(16), .DW(16)) bif ();

    // PC registers and memories on the slave side of each DUT
    always @(posedge clk) if (!mif.pc_load_n) pc_reg <= mif.pc_d;
    always @(posedge clk) if (!bif.pc_load_n) pc_reg_b <= bif.pc_d;
    assign mif.pc_q      = pc_reg;
    assign mif.imem_ack  = m_ack;
    assign mif.imem_data = mem_word(mif.imem_addr);
    assign bif.pc_q      = pc_reg_b;
    assign bif.imem_ack  = 1'b1;
    assign bif.imem_data = 16'hA001;

    fetch_seq #(.AW(16), .DW(16), .INC(2), .RESET_PC(16'h0000)) dut (
        .clk(clk), .clr(clr), .bus(mif), .stall(stall), .br_valid(br_valid),
        .br_target(br_target), .halt(halt), .ir(ir), .ir_pc(ir_pc),
        .ir_valid(ir_valid), .halted(halted)
    );

    fetch_seq #(.AW(16), .DW(16), .INC(2), .RESET_PC(16'h0040)) dut_b (
        .clk(clk), .clr(clr), .bus(bif), .stall(1'b0), .br_valid(1'b0),
        .br_target(16'h0000), .halt(1'b0), .ir(ir_b), .ir_pc(ir_pc_b),
        .ir_valid(ir_valid_b), .halted(halted_b)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        clr = 1'b0; stall = 1'b0; br_valid = 1'b0; halt = 1'b0; m_ack = 1'b0; br_target = 16'h0000;
        cyc();
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (mif.imem_req !== 1'b0 || mif.pc_load_n !== 1'b1 || mif.pc_d !== 16'h0000 || halted !== 1'b0) begin bad++; $display("FAIL rst_comb got req=%b ld_n=%b pc_d=%h halted=%b exp 0/1/0000/0", mif.imem_req, mif.pc_load_n, mif.pc_d, halted); end
            total++; if (ir !== 16'h0000 || ir_pc !== 16'h0000 || ir_valid !== 1'b0 || mif.imem_addr !== 16'h0000) begin bad++; $display("FAIL rst_regs got ir=%h ir_pc=%h v=%b addr=%h exp zeros", ir, ir_pc, ir_valid, mif.imem_addr); end
            total++; if (bif.imem_req !== 1'b0 || bif.pc_load_n !== 1'b1 || ir_valid_b !== 1'b0) begin bad++; $display("FAIL rst_b got req=%b ld_n=%b v=%b exp 0/1/0", bif.imem_req, bif.pc_load_n, ir_valid_b); end
            if (k == 0) cyc();
        end
        clr = 1'b1;
        #1;
        total++; if (bif.pc_load_n !== 1'b0 || bif.pc_d !== 16'h0040) begin bad++; $display("FAIL boot_b got ld_n=%b pc_d=%h exp 0/0040", bif.pc_load_n, bif.pc_d); end
        total++; if (mif.pc_load_n !== 1'b0 || mif.pc_d !== 16'h0000 || mif.imem_req !== 1'b0) begin bad++; $display("FAIL boot got ld_n=%b pc_d=%h req=%b exp 0/0000/0", mif.pc_load_n, mif.pc_d, mif.imem_req); end
        cyc(); #1;
        total++; if (bif.imem_req !== 1'b1 || bif.imem_addr !== 16'h0040) begin bad++; $display("FAIL req_b got req=%b addr=%h exp 1/0040", bif.imem_req, bif.imem_addr); end
        cyc(); #1;
        total++; if (ir_b !== 16'hA001 || ir_pc_b !== 16'h0040 || ir_valid_b !== 1'b1) begin bad++; $display("FAIL ir_b got ir=%h pc=%h v=%b exp A001/0040/1", ir_b, ir_pc_b, ir_valid_b); end
    endtask

    task automatic test_seq();
        m_ack = 1'b1; stall = 1'b0;
        #1;
        total++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 16'h0000 || mif.pc_load_n !== 1'b0 || mif.pc_d !== 16'h0002) begin bad++; $display("FAIL seq_req0 got req=%b addr=%h ld_n=%b pc_d=%h exp 1/0000/0/0002", mif.imem_req, mif.imem_addr, mif.pc_load_n, mif.pc_d); end
        cyc(); #1;
        total++; if (ir !== 16'h1111 || ir_pc !== 16'h0000 || ir_valid !== 1'b1 || mif.imem_req !== 1'b0 || mif.pc_load_n !== 1'b1) begin bad++; $display("FAIL seq_v0 got ir=%h pc=%h v=%b req=%b ld_n=%b exp 1111/0000/1/0/1", ir, ir_pc, ir_valid, mif.imem_req, mif.pc_load_n); end
        cyc(); #1;
        total++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 16'h0002 || mif.pc_load_n !== 1'b0 || mif.pc_d !== 16'h0004) begin bad++; $display("FAIL seq_req1 got req=%b addr=%h ld_n=%b pc_d=%h exp 1/0002/0/0004", mif.imem_req, mif.imem_addr, mif.pc_load_n, mif.pc_d); end
        cyc();
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (ir !== 16'h2222 || ir_pc !== 16'h0002 || ir_valid !== 1'b1 || mif.pc_load_n !== 1'b1 || mif.imem_req !== 1'b0) begin bad++; $display("FAIL stall_hold%0d got ir=%h pc=%h v=%b ld_n=%b req=%b exp 2222/0002/1/1/0", k, ir, ir_pc, ir_valid, mif.pc_load_n, mif.imem_req); end
            cyc();
        end
        stall = 1'b0;
        #1;
        total++; if (ir_valid !== 1'b1 || mif.imem_req !== 1'b0) begin bad++; $display("FAIL stall_drop got v=%b req=%b exp 1/0", ir_valid, mif.imem_req); end
        cyc(); #1;
        total++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 16'h0004 || ir_valid !== 1'b0) begin bad++; $display("FAIL stall_req got req=%b addr=%h v=%b exp 1/0004/0", mif.imem_req, mif.imem_addr, ir_valid); end
        cyc(); #1;
        total++; if (ir !== 16'h3333 || ir_pc !== 16'h0004 || ir_valid !== 1'b1) begin bad++; $display("FAIL seq_v2 got ir=%h pc=%h v=%b exp 3333/0004/1", ir, ir_pc, ir_valid); end
    endtask

    task automatic test_branch_valid();
        stall = 1'b1; br_valid = 1'b1; br_target = 16'h0100; m_ack = 1'b0;
        #1;
        total++; if (mif.pc_load_n !== 1'b0 || mif.pc_d !== 16'h0100) begin bad++; $display("FAIL brv_load got ld_n=%b pc_d=%h exp 0/0100", mif.pc_load_n, mif.pc_d); end
        cyc();
        stall = 1'b0; br_valid = 1'b0;
        #1;
        total++; if (ir_valid !== 1'b0 || mif.imem_addr !== 16'h0100 || mif.imem_req !== 1'b1) begin bad++; $display("FAIL brv_req got v=%b addr=%h req=%b exp 0/0100/1", ir_valid, mif.imem_addr, mif.imem_req); end
    endtask

    task automatic test_branch_pend();
        br_valid = 1'b1; br_target = 16'h0200;
        #1;
        total++; if (mif.pc_load_n !== 1'b0 || mif.pc_d !== 16'h0200 || mif.imem_addr !== 16'h0100) begin bad++; $display("FAIL brp_load got ld_n=%b pc_d=%h addr=%h exp 0/0200/0100", mif.pc_load_n, mif.pc_d, mif.imem_addr); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            br_valid = 1'b0; m_ack = (k == 2);
            #1;
            total++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 16'h0100 || mif.pc_load_n !== 1'b1) begin bad++; $display("FAIL brp_hold%0d got req=%b addr=%h ld_n=%b exp 1/0100/1", k, mif.imem_req, mif.imem_addr, mif.pc_load_n); end
        end
        cyc();
        m_ack = 1'b0;
        #1;
        total++; if (ir_valid !== 1'b0 || ir_pc !== 16'h0004 || mif.imem_addr !== 16'h0200 || mif.imem_req !== 1'b1) begin bad++; $display("FAIL brp_redir got v=%b pc=%h addr=%h req=%b exp 0/0004/0200/1", ir_valid, ir_pc, mif.imem_addr, mif.imem_req); end
    endtask

    task automatic test_halt_wrap();
        m_ack = 1'b1;
        cyc();
        m_ack = 1'b0; br_valid = 1'b1; br_target = 16'hFFFE;
        #1;
        total++; if (ir_pc !== 16'h0200 || ir !== mem_word(16'h0200) || ir_valid !== 1'b1) begin bad++; $display("FAIL wrap_v200 got ir=%h pc=%h v=%b exp %h/0200/1", ir, ir_pc, ir_valid, mem_word(16'h0200)); end
        cyc();
        br_valid = 1'b0; m_ack = 1'b1;
        #1;
        total++; if (mif.imem_addr !== 16'hFFFE || mif.pc_load_n !== 1'b0 || mif.pc_d !== 16'h0000) begin bad++; $display("FAIL wrap_pcd got addr=%h ld_n=%b pc_d=%h exp FFFE/0/0000", mif.imem_addr, mif.pc_load_n, mif.pc_d); end
        cyc();
        m_ack = 1'b0; halt = 1'b1; stall = 1'b1;
        #1;
        total++; if (ir_pc !== 16'hFFFE || ir !== mem_word(16'hFFFE) || halted !== 1'b0) begin bad++; $display("FAIL wrap_vfffe got ir=%h pc=%h halted=%b exp %h/FFFE/0", ir, ir_pc, halted, mem_word(16'hFFFE)); end
        cyc();
        halt = 1'b0; stall = 1'b0;
        #1;
        total++; if (ir_valid !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL halt_pend got v=%b halted=%b exp 1/0", ir_valid, halted); end
        for (int k = 0; k < 5; k++) begin
            cyc();
            m_ack = 1'($urandom); br_valid = 1'($urandom); br_target = 16'h0300;
            #1;
            total++; if (halted !== 1'b1 || mif.imem_req !== 1'b0 || mif.pc_load_n !== 1'b1 || ir_valid !== 1'b0) begin bad++; $display("FAIL halt%0d got halted=%b req=%b ld_n=%b v=%b exp 1/0/1/0", k, halted, mif.imem_req, mif.pc_load_n, ir_valid); end
        end
        br_valid = 1'b0; m_ack = 1'b0;
    endtask

    task automatic test_midfetch_reset();
        clr = 1'b0;
        cyc();
        clr = 1'b1;
        #1;
        total++; if (mif.pc_load_n !== 1'b0 || mif.pc_d !== 16'h0000 || halted !== 1'b0) begin bad++; $display("FAIL mid_boot1 got ld_n=%b pc_d=%h halted=%b exp 0/0000/0", mif.pc_load_n, mif.pc_d, halted); end
        cyc(); cyc();
        #1;
        total++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 16'h0000) begin bad++; $display("FAIL mid_wait got req=%b addr=%h exp 1/0000", mif.imem_req, mif.imem_addr); end
        clr = 1'b0;
        cyc(); #1;
        total++; if (mif.imem_req !== 1'b0) begin bad++; $display("FAIL mid_drop got req=%b exp 0", mif.imem_req); end
        clr = 1'b1;
        #1;
        total++; if (mif.pc_load_n !== 1'b0 || mif.pc_d !== 16'h0000 || mif.imem_req !== 1'b0) begin bad++; $display("FAIL mid_boot2 got ld_n=%b pc_d=%h req=%b exp 0/0000/0", mif.pc_load_n, mif.pc_d, mif.imem_req); end
        cyc(); #1;
        total++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 16'h0000) begin bad++; $display("FAIL mid_req got req=%b addr=%h exp 1/0000", mif.imem_req, mif.imem_addr); end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc, tgt, prev_addr;
        logic        prev_wait;
        int          idle, ndel;
        clr = 1'b0; stall = 1'b0; br_valid = 1'b0; halt = 1'b0; m_ack = 1'b0;
        cyc();
        clr = 1'b1;
        exp_pc = 16'h0000; prev_wait = 1'b0; prev_addr = 16'h0000; idle = 0; ndel = 0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            br_valid  = (mif.imem_req || ir_valid) && ($urandom_range(9, 0) == 0);
            tgt       = 16'($urandom) & 16'hFFFE;
            br_target = tgt;
            m_ack     = ($urandom_range(2, 0) == 0);
            stall     = ($urandom_range(2, 0) == 0);
            #1;
            if (prev_wait) begin
                total++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== prev_addr) begin bad++; $display("FAIL rnd_hold cyc=%0d got req=%b addr=%h exp 1/%h", n, mif.imem_req, mif.imem_addr, prev_addr); end
            end
            prev_wait = mif.imem_req && !m_ack;
            prev_addr = mif.imem_addr;
            if (ir_valid && !stall && !br_valid) begin
                total++; if (ir_pc !== exp_pc || ir !== mem_word(exp_pc)) begin bad++; $display("FAIL rnd_deliver cyc=%0d got ir=%h pc=%h exp %h/%h", n, ir, ir_pc, mem_word(exp_pc), exp_pc); end
                exp_pc = exp_pc + 16'd2;
                ndel++;
                idle = 0;
            end else begin
                idle++;
            end
            if (br_valid) exp_pc = tgt;
            if (idle > 200) begin
                total++; bad++; $display("FAIL rnd_timeout cyc=%0d got no delivery for %0d cycles exp progress", n, idle);
                break;
            end
        end
        br_valid = 1'b0; stall = 1'b0; m_ack = 1'b0;
        total++; if (ndel < 100) begin bad++; $display("FAIL rnd_count got %0d deliveries exp >=100", ndel); end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_stall();
        test_branch_valid();
        test_branch_pend();
        test_halt_wrap();
        test_midfetch_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
